pilot_extract: RTL and testbench
================================

# pilot_extract

Receive-side companion to the transmit pilot inserter. Consumes the pilot-bearing sample stream and separates pilot samples from data samples using the same `frame_length` / `pilot_interval` framing. Forwards data samples downstream with a frame-last marker, and emits pilots on a side strobe for channel estimation. Compares every pilot against `pilot_value` and counts mismatches.

## Interface
Parameters:
- `DATA_W`, 32, sample width (I/Q packed)
- `CNT_W`, 13, width of frame/pilot counters and config inputs
- `MISS_W`, 16, width of saturating mismatch counter

Ports:
- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  reset, synchronous, active-high
- `s_data`  in  DATA_W  input sample
- `s_valid`  in  1  input sample valid
- `s_ready`  out  1  block accepts sample this cycle
- `frame_length`  in  CNT_W  samples per frame, pilots included
- `pilot_interval`  in  CNT_W  pilot spacing; 0 = no pilots
- `pilot_value`  in  DATA_W  expected pilot symbol
- `m_data`  out  DATA_W  data sample out
- `m_valid`  out  1  output valid
- `m_ready`  in  1  downstream ready
- `m_last`  out  1  with `m_valid`: last data sample of frame
- `p_data`  out  DATA_W  extracted pilot
- `p_valid`  out  1  one-cycle pilot strobe, no backpressure
- `pilot_mismatch`  out  1  with `p_valid`: `p_data != pilot_value`
- `miss_count`  out  MISS_W  saturating mismatch total
- `frame_done`  out  1  one-cycle strobe, last sample of a frame accepted
- `cfg_error`  out  1  latched config illegal

## Operation
- Accept: `acc = s_valid && s_ready`; `s_ready = !cfg_error && (!m_valid || m_ready)`.
- Counters `cnt_frame` (0..L-1) and `cnt_pilot` (0..P-1) advance only on `acc`. Both clear on the last sample of a frame, so pilot phase realigns every frame.
- Config latch: `L = frame_length` and `P = pilot_interval` are sampled when `cnt_frame == 0` and the block is idle or `acc`. They are held for the whole frame; mid-frame config changes are ignored.
- `cfg_error` is set when the latched `L < 2`. While set, `s_ready = 0`. It is re-evaluated every cycle while `cnt_frame == 0`, and clears once config is legal.
- Sample is a pilot iff `P != 0 && cnt_pilot == 0`. Pilot samples go to `p_data`/`p_valid`/`pilot_mismatch` and are never on `m_*`. `miss_count` increments on a mismatch and saturates at all-ones.
- Data samples are loaded into the output register.
- `m_last` is set when either:
  - `cnt_frame == L-1`, or
  - `cnt_frame == L-2` and the next index is a pilot (`P != 0 && cnt_pilot == P-1`), or `P == 1`.
- No modulo or division hardware; `cnt_pilot` wraps at `P-1`.
- `P == 1`: every sample is a pilot, and `m_valid` never asserts.
- `P == 0`: all samples are data.
- `P >= L`: only index 0 is a pilot.

## Timing
- Reset values:
  - `s_ready` 0 during reset, then 1 the cycle after `rst` deasserts when config is legal.
  - `m_valid` 0, `m_last` 0, `m_data` 0.
  - `p_valid` 0, `p_data` 0, `pilot_mismatch` 0.
  - `miss_count` 0, `frame_done` 0, `cfg_error` 0.
  - Counters 0.
- Latency: 1 cycle from `acc` to `m_valid`, `p_valid`, `pilot_mismatch` and `frame_done`.
- `m_*` holds stable while `m_valid && !m_ready`. A new data sample loads on the same cycle the old one drains, giving full throughput (one sample per clock with `m_ready` high).
- Pilot acceptance is gated by `s_ready` the same as data, so pilot order relative to data is preserved.
- `rst` mid-frame: counters, output register and strobes clear on the next edge; any pending `m_*` sample is dropped.
- Simultaneous last-sample-of-frame and pilot: `p_valid` and `frame_done` assert together.

## Structure
- Shared package `pilot_pkg`: `DATA_W`, `CNT_W` defaults and a `sample_t` typedef. The transmit inserter uses the same package.
- One sub-module: `pilot_out_reg`, a single-stage valid/ready register carrying `{m_last, m_data}`. Counter and classification logic stays in the top.

## Test plan
- L=8, P=4, continuous input 0..15, `m_ready`=1:
  - Pilots at indices 0, 4, 8, 12.
  - Data out is 1,2,3,5,6,7,9,10,11,13,14,15.
  - `m_last` on 7 and 15; `frame_done` twice.
- L=7, P=3: the last sample (index 6) is a pilot. `m_last` is on index 5; `p_valid` and `frame_done` coincide for index 6.
- L=8, P=4 with `m_ready` toggling 1-0-0-1: no loss or duplication, `m_data` stable while stalled, `s_ready` low only while the register is full and `m_ready`=0.
- `pilot_value` = 0x00010001, one pilot corrupted to 0x00010002: one `pilot_mismatch` strobe and `miss_count`=1. Forcing 2^16+3 mismatches gives `miss_count`=0xFFFF.
- `frame_length`=1 at reset release: `cfg_error`=1 and `s_ready`=0. Changing to L=4 clears `cfg_error` next cycle, and the stream resumes from index 0.
- `rst` asserted at index 5 of an L=8 frame: all outputs reach reset values next edge, and the next accepted sample is treated as index 0 (a pilot).

Source files
------------

// File: rtl/pilot_pkg.sv
// rtl/pilot_pkg.sv - shared pilot framing defaults and sample type
package pilot_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 13;
    localparam int DEF_MISS_W = 16;

    typedef logic [DEF_DATA_W-1:0] sample_t;
endpackage

// File: rtl/pilot_out_reg.sv
// rtl/pilot_out_reg.sv - single-stage valid/ready output register
module pilot_out_reg #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    // Ready whenever the slot is empty or draining this cycle, so back-to-back loads run at full rate.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end
endmodule

// File: rtl/pilot_extract.sv
// rtl/pilot_extract.sv - separates pilot samples from data samples per frame
module pilot_extract
    import pilot_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int MISS_W = DEF_MISS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [CNT_W-1:0]  frame_length,
    input  logic [CNT_W-1:0]  pilot_interval,
    input  logic [DATA_W-1:0] pilot_value,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [DATA_W-1:0] p_data,
    output logic              p_valid,
    output logic              pilot_mismatch,
    output logic [MISS_W-1:0] miss_count,
    output logic              frame_done,
    output logic              cfg_error
);
    logic [CNT_W-1:0] cnt_frame, cnt_pilot;
    logic [CNT_W-1:0] len_q, ivl_q, len_eff, ivl_eff;
    logic             frame_start, cfg_bad, reg_ready, acc;
    logic             is_pilot, at_last, last_data, mismatch;

    // At frame start the live config applies; from index 1 on, the copy taken at index 0 is used.
    assign frame_start = (cnt_frame == '0);
    assign len_eff     = frame_start ? frame_length : len_q;
    assign ivl_eff     = frame_start ? pilot_interval : ivl_q;
    assign cfg_bad     = frame_start ? (frame_length < CNT_W'(2)) : cfg_error;

    assign s_ready = !rst && !cfg_bad && reg_ready;
    assign acc     = s_valid && s_ready;

    assign is_pilot  = (ivl_eff != '0) && (cnt_pilot == '0);
    assign at_last   = (cnt_frame == len_eff - CNT_W'(1));
    // Last data sample is either the frame's final index or the one just before a trailing pilot.
    assign last_data = at_last
                    || ((cnt_frame == len_eff - CNT_W'(2))
                        && (ivl_eff != '0) && (cnt_pilot == ivl_eff - CNT_W'(1)));
    assign mismatch  = (s_data != pilot_value);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_frame      <= '0;
            cnt_pilot      <= '0;
            len_q          <= '0;
            ivl_q          <= '0;
            cfg_error      <= 1'b0;
            p_data         <= '0;
            p_valid        <= 1'b0;
            pilot_mismatch <= 1'b0;
            miss_count     <= '0;
            frame_done     <= 1'b0;
        end else begin
            if (frame_start) begin
                len_q     <= frame_length;
                ivl_q     <= pilot_interval;
                cfg_error <= (frame_length < CNT_W'(2));
            end
            p_valid        <= acc && is_pilot;
            pilot_mismatch <= acc && is_pilot && mismatch;
            frame_done     <= acc && at_last;
            if (acc && is_pilot) begin
                p_data <= s_data;
                if (mismatch && (miss_count != '1)) begin
                    miss_count <= miss_count + 1'b1;
                end
            end
            if (acc) begin
                if (at_last) begin
                    cnt_frame <= '0;
                    cnt_pilot <= '0;
                end else begin
                    cnt_frame <= cnt_frame + 1'b1;
                    cnt_pilot <= (cnt_pilot == ivl_eff - CNT_W'(1)) ? '0 : cnt_pilot + 1'b1;
                end
            end
        end
    end

    pilot_out_reg #(.W(DATA_W + 1)) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({last_data, s_data}),
        .in_valid  (acc && !is_pilot),
        .in_ready  (reg_ready),
        .out_data  ({m_last, m_data}),
        .out_valid (m_valid),
        .out_ready (m_ready)
    );
endmodule

// File: tb/tb_pilot_extract.sv
// tb/tb_pilot_extract.sv - directed self-checking bench for pilot_extract
module tb_pilot_extract;
    import pilot_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    sample_t     s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [12:0] frame_length = 13'd8;
    logic [12:0] pilot_interval = 13'd4;
    sample_t     pilot_value = '0;
    sample_t     m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_last;
    sample_t     p_data;
    logic        p_valid;
    logic        pilot_mismatch;
    logic [15:0] miss_count;
    logic        frame_done;
    logic        cfg_error;

    int n_tests = 0;
    int n_fail  = 0;

    sample_t got_data[$];
    logic    got_last[$];
    sample_t got_pil[$];
    sample_t stim[$];
    int      fd_cnt, co_cnt, mm_cnt, stall_viol, stall_n, rdy_viol;
    bit      mon_chk = 1'b0;
    bit      held_v = 1'b0;
    sample_t held = '0;

    pilot_extract dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .frame_length(frame_length), .pilot_interval(pilot_interval), .pilot_value(pilot_value),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .p_data(p_data), .p_valid(p_valid), .pilot_mismatch(pilot_mismatch),
        .miss_count(miss_count), .frame_done(frame_done), .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            got_data.push_back(m_data);
            got_last.push_back(m_last);
        end
        if (p_valid) got_pil.push_back(p_data);
        if (frame_done) begin
            fd_cnt++;
            if (p_valid) co_cnt++;
        end
        if (p_valid && pilot_mismatch) mm_cnt++;
        if (held_v && (!m_valid || m_data !== held)) stall_viol++;
        held_v = m_valid && !m_ready;
        held   = m_data;
        if (held_v) stall_n++;
        if (mon_chk && !rst && (s_ready !== (!m_valid || m_ready))) rdy_viol++;
    end

    task automatic clear_mon();
        got_data.delete(); got_last.delete(); got_pil.delete();
        fd_cnt = 0; co_cnt = 0; mm_cnt = 0; stall_viol = 0; stall_n = 0; rdy_viol = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();
    endtask

    task automatic run_stream(input bit toggle);
        bit [3:0] pat = 4'b1001;
        int i = 0;
        int cyc = 0;
        while (i < stim.size() && cyc < 2000) begin
            s_valid = 1'b1;
            s_data  = stim[i];
            m_ready = toggle ? pat[cyc % 4] : 1'b1;
            @(negedge clk);
            if (s_ready) i++;
            @(posedge clk);
            #1 cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (i != stim.size()) begin
            n_fail++;
            $display("FAIL stream_accept got %0d samples required %0d", i, stim.size());
        end
    endtask

    task automatic load_ramp(input int n, input int base);
        stim.delete();
        for (int k = 0; k < n; k++) stim.push_back(sample_t'(base + k));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({s_ready, m_valid, m_last, p_valid, pilot_mismatch, frame_done, cfg_error} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b required 0000000",
                     {s_ready, m_valid, m_last, p_valid, pilot_mismatch, frame_done, cfg_error});
        end
        n_tests++;
        if (m_data !== '0 || p_data !== '0 || miss_count !== '0) begin
            n_fail++;
            $display("FAIL reset_data got m=%h p=%h miss=%h required 0", m_data, p_data, miss_count);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready got %b required 1", s_ready);
        end
    endtask

    task automatic check_l8p4(input string tag);
        sample_t exp_d[12] = '{1, 2, 3, 5, 6, 7, 9, 10, 11, 13, 14, 15};
        sample_t exp_p[4]  = '{0, 4, 8, 12};
        n_tests++;
        if (got_data.size() != 12 || got_pil.size() != 4) begin
            n_fail++;
            $display("FAIL %s_count got data=%0d pilots=%0d required 12/4", tag, got_data.size(), got_pil.size());
        end
        for (int k = 0; k < 12 && k < got_data.size(); k++) begin
            n_tests++;
            if (got_data[k] !== exp_d[k] || got_last[k] !== (exp_d[k] == 7 || exp_d[k] == 15)) begin
                n_fail++;
                $display("FAIL %s_data[%0d] got %h last=%b required %h", tag, k, got_data[k], got_last[k], exp_d[k]);
            end
        end
        for (int k = 0; k < 4 && k < got_pil.size(); k++) begin
            n_tests++;
            if (got_pil[k] !== exp_p[k]) begin
                n_fail++;
                $display("FAIL %s_pilot[%0d] got %h required %h", tag, k, got_pil[k], exp_p[k]);
            end
        end
        n_tests++;
        if (fd_cnt != 2) begin
            n_fail++;
            $display("FAIL %s_frame_done got %0d required 2", tag, fd_cnt);
        end
    endtask

    task automatic test_basic();
        frame_length = 13'd8; pilot_interval = 13'd4; pilot_value = '0;
        do_reset();
        load_ramp(16, 0);
        run_stream(1'b0);
        check_l8p4("basic");
    endtask

    task automatic test_trailing_pilot();
        sample_t exp_d[4] = '{1, 2, 4, 5};
        frame_length = 13'd7; pilot_interval = 13'd3;
        do_reset();
        load_ramp(7, 0);
        run_stream(1'b0);
        n_tests++;
        if (got_data.size() != 4 || got_pil.size() != 3) begin
            n_fail++;
            $display("FAIL l7p3_count got data=%0d pilots=%0d required 4/3", got_data.size(), got_pil.size());
        end
        for (int k = 0; k < 4 && k < got_data.size(); k++) begin
            n_tests++;
            if (got_data[k] !== exp_d[k] || got_last[k] !== (k == 3)) begin
                n_fail++;
                $display("FAIL l7p3_data[%0d] got %h last=%b required %h last=%b", k, got_data[k], got_last[k], exp_d[k], k == 3);
            end
        end
        n_tests++;
        if (got_pil.size() == 3 && got_pil[2] !== 32'd6) begin
            n_fail++;
            $display("FAIL l7p3_last_pilot got %h required 6", got_pil[2]);
        end
        n_tests++;
        if (fd_cnt != 1 || co_cnt != 1) begin
            n_fail++;
            $display("FAIL l7p3_coincide got done=%0d coincide=%0d required 1/1", fd_cnt, co_cnt);
        end
    endtask

    task automatic test_back_to_back_stall();
        frame_length = 13'd8; pilot_interval = 13'd4;
        do_reset();
        load_ramp(16, 0);
        mon_chk = 1'b1;
        run_stream(1'b1);
        mon_chk = 1'b0;
        check_l8p4("stall");
        n_tests++;
        if (stall_viol != 0 || stall_n == 0) begin
            n_fail++;
            $display("FAIL stall_hold got violations=%0d stalls=%0d required 0/>0", stall_viol, stall_n);
        end
        n_tests++;
        if (rdy_viol != 0) begin
            n_fail++;
            $display("FAIL stall_ready got violations=%0d required 0", rdy_viol);
        end
    endtask

    task automatic test_mismatch();
        frame_length = 13'd8; pilot_interval = 13'd4; pilot_value = 32'h0001_0001;
        do_reset();
        load_ramp(8, 0);
        stim[0] = 32'h0001_0001;
        stim[4] = 32'h0001_0002;
        run_stream(1'b0);
        n_tests++;
        if (mm_cnt != 1 || miss_count !== 16'd1) begin
            n_fail++;
            $display("FAIL mismatch_count got strobes=%0d miss=%0d required 1/1", mm_cnt, miss_count);
        end
        n_tests++;
        if (got_pil.size() != 2 || got_pil[1] !== 32'h0001_0002 || got_data.size() != 6) begin
            n_fail++;
            $display("FAIL mismatch_stream got pilots=%0d data=%0d required 2/6", got_pil.size(), got_data.size());
        end
    endtask

    task automatic test_saturation();
        frame_length = 13'd2; pilot_interval = 13'd1; pilot_value = '0;
        do_reset();
        s_data = 32'd1; s_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if (miss_count !== 16'd10) begin
            n_fail++;
            $display("FAIL sat_partial got %0d required 10", miss_count);
        end
        repeat (65529) @(posedge clk);
        #1 s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (miss_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_full got %h required ffff", miss_count);
        end
        n_tests++;
        if (got_data.size() != 0) begin
            n_fail++;
            $display("FAIL sat_no_data got %0d data samples required 0", got_data.size());
        end
        clear_mon();
    endtask

    task automatic test_cfg_error();
        frame_length = 13'd1; pilot_interval = 13'd4; pilot_value = '0;
        rst = 1'b1; s_valid = 1'b1; s_data = 32'h99; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();
        #1;
        n_tests++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_release_ready got %b required 0", s_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (cfg_error !== 1'b1 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_error_set got err=%b ready=%b required 1/0", cfg_error, s_ready);
        end
        s_valid = 1'b0;
        frame_length = 13'd4;
        @(posedge clk);
        #1;
        n_tests++;
        if (cfg_error !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_error_clear got err=%b ready=%b required 0/1", cfg_error, s_ready);
        end
        n_tests++;
        if (got_data.size() != 0 || got_pil.size() != 0) begin
            n_fail++;
            $display("FAIL cfg_blocked got data=%0d pilots=%0d required 0/0", got_data.size(), got_pil.size());
        end
        load_ramp(4, 16);
        run_stream(1'b0);
        n_tests++;
        if (got_pil.size() != 1 || got_pil[0] !== 32'h10 || got_data.size() != 3) begin
            n_fail++;
            $display("FAIL cfg_resume got pilots=%0d data=%0d required 1/3", got_pil.size(), got_data.size());
        end
        n_tests++;
        if (got_data.size() == 3 && (got_data[2] !== 32'h13 || got_last[2] !== 1'b1 || got_last[1] !== 1'b0)) begin
            n_fail++;
            $display("FAIL cfg_resume_last got %h last=%b required 13 last=1", got_data[2], got_last[2]);
        end
    endtask

    task automatic test_mid_reset();
        frame_length = 13'd8; pilot_interval = 13'd4; pilot_value = '0;
        do_reset();
        load_ramp(5, 0);
        run_stream(1'b0);
        s_valid = 1'b1; s_data = 32'd5; m_ready = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 32'd5) begin
            n_fail++;
            $display("FAIL midrst_pending got valid=%b data=%h required 1/5", m_valid, m_data);
        end
        rst = 1'b1; s_data = 32'd6;
        @(posedge clk);
        #1;
        n_tests++;
        if ({m_valid, m_last, p_valid, pilot_mismatch, frame_done, cfg_error, s_ready} !== 7'b0
            || m_data !== '0 || p_data !== '0 || miss_count !== '0) begin
            n_fail++;
            $display("FAIL midrst_clear got flags=%b m=%h p=%h miss=%h required all 0",
                     {m_valid, m_last, p_valid, pilot_mismatch, frame_done, cfg_error, s_ready},
                     m_data, p_data, miss_count);
        end
        rst = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        clear_mon();
        load_ramp(2, 256);
        run_stream(1'b0);
        n_tests++;
        if (got_pil.size() != 1 || got_pil[0] !== 32'h100 || got_data.size() != 1
            || got_data[0] !== 32'h101 || got_last[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_restart got pilots=%0d data=%0d required pilot 100 then data 101",
                     got_pil.size(), got_data.size());
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_trailing_pilot();
        test_back_to_back_stall();
        test_mismatch();
        test_saturation();
        test_cfg_error();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
